// File: rtl/vending_machine_core_if.sv
// Coin/button front-end and actuator signals of the vending-machine core.
// The master drives customer inputs and price tables; the slave (core) drives the actuator outputs.
interface vending_machine_core_if #(
  parameter int NUM_ITEMS  = 4,
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 16
);
  logic [NUM_COINS-1:0]            i_input_coin;
  logic [NUM_ITEMS-1:0]            i_select_item;
  logic                            i_trigger_return;
  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price;
  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value;
  logic [NUM_ITEMS-1:0]            o_available_item;
  logic [NUM_ITEMS-1:0]            o_output_item;
  logic [NUM_COINS-1:0]            o_return_coin;
  logic                            o_coin_reject;
  logic [TOTAL_BITS-1:0]           o_current_total;
  logic                            o_busy;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return, i_item_price, i_coin_value,
    input  o_available_item, o_output_item, o_return_coin, o_coin_reject,
           o_current_total, o_busy
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return, i_item_price, i_coin_value,
    output o_available_item, o_output_item, o_return_coin, o_coin_reject,
           o_current_total, o_busy
  );
endinterface

// File: rtl/vending_machine_core.sv
// Sequential vending-machine controller: coin accumulation, idle timeout,
// item dispense pulses and greedy largest-first change return.
module vending_machine_core #(
  parameter int NUM_ITEMS   = 4,
  parameter int NUM_COINS   = 3,
  parameter int TOTAL_BITS  = 16,
  parameter int WAIT_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  vending_machine_core_if.slave bus
);
  localparam int TIMER_BITS = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LOAD = TIMER_BITS'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_RETURN   = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [TOTAL_BITS-1:0]  total_r, total_s;
  logic [TIMER_BITS-1:0]  timer_r, timer_s;
  logic [NUM_ITEMS-1:0]   item_r, item_s;
  logic [NUM_COINS-1:0]   ret_r, ret_s;
  logic                   reject_r, reject_s;
  logic                   busy_r, busy_s;

  logic [NUM_COINS-1:0]   coin_oh_s;
  logic [TOTAL_BITS-1:0]  coin_val_s;
  logic [TOTAL_BITS:0]    coin_sum_s;
  logic                   coin_hit_s;
  logic                   coin_ok_s;
  logic [TOTAL_BITS-1:0]  base_s;
  logic [NUM_COINS-1:0]   fit_s;
  logic [NUM_COINS-1:0]   ret_oh_s;
  logic [TOTAL_BITS-1:0]  ret_val_s;
  logic [NUM_ITEMS-1:0]   avail_s;
  logic [NUM_ITEMS-1:0]   sel_ok_s;
  logic [NUM_ITEMS-1:0]   pick_oh_s;
  logic [TOTAL_BITS-1:0]  pick_price_s;

  // Coin decode, overflow check and greedy change-coin choice.
  always_comb begin
    coin_oh_s  = bus.i_input_coin & (~bus.i_input_coin + NUM_COINS'(1));
    coin_val_s = '0;
    fit_s      = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      coin_val_s = coin_val_s |
                   ({TOTAL_BITS{coin_oh_s[j]}} & bus.i_coin_value[j*TOTAL_BITS +: TOTAL_BITS]);
      fit_s[j]   = (bus.i_coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= total_r);
    end
    coin_hit_s = |bus.i_input_coin;
    coin_sum_s = {1'b0, total_r} + {1'b0, coin_val_s};
    coin_ok_s  = coin_hit_s & ~coin_sum_s[TOTAL_BITS];
    base_s     = coin_ok_s ? coin_sum_s[TOTAL_BITS-1:0] : total_r;
    // Values rise with index, so fit_s is a thermometer code; keep its top bit.
    ret_oh_s   = fit_s & ~(fit_s >> 1);
    ret_val_s  = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      ret_val_s = ret_val_s |
                  ({TOTAL_BITS{ret_oh_s[j]}} & bus.i_coin_value[j*TOTAL_BITS +: TOTAL_BITS]);
    end
  end

  // Affordability mask and lowest-index affordable selection.
  always_comb begin
    avail_s = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_s[i] = (state_r == ST_WAIT) &&
                   (total_r >= bus.i_item_price[i*TOTAL_BITS +: TOTAL_BITS]);
    end
    sel_ok_s     = bus.i_select_item & avail_s;
    pick_oh_s    = sel_ok_s & (~sel_ok_s + NUM_ITEMS'(1));
    pick_price_s = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      pick_price_s = pick_price_s |
                     ({TOTAL_BITS{pick_oh_s[i]}} & bus.i_item_price[i*TOTAL_BITS +: TOTAL_BITS]);
    end
  end

  // Next-state, next-total, timer and next-output decisions.
  always_comb begin
    state_s  = state_r;
    total_s  = total_r;
    timer_s  = timer_r;
    item_s   = '0;
    ret_s    = '0;
    reject_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) begin
          total_s = base_s;
          timer_s = TIMER_LOAD;
          state_s = ST_WAIT;
        end else begin
          reject_s = coin_hit_s;
        end
      end
      ST_WAIT: begin
        reject_s = coin_hit_s & ~coin_ok_s;
        if (bus.i_trigger_return) begin
          total_s = base_s;
          state_s = ST_RETURN;
        end else if (|pick_oh_s) begin
          total_s = base_s - pick_price_s;
          item_s  = pick_oh_s;
          timer_s = TIMER_LOAD;
          state_s = ST_DISPENSE;
        end else if (coin_ok_s) begin
          total_s = base_s;
          timer_s = TIMER_LOAD;
        end else if (timer_r == TIMER_BITS'(0)) begin
          state_s = ST_RETURN;
        end else begin
          timer_s = timer_r - TIMER_BITS'(1);
        end
      end
      ST_DISPENSE: begin
        reject_s = coin_hit_s;
        if (total_r != TOTAL_BITS'(0)) begin
          timer_s = TIMER_LOAD;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RETURN: begin
        reject_s = coin_hit_s;
        if (|ret_oh_s) begin
          ret_s   = ret_oh_s;
          total_s = total_r - ret_val_s;
        end else begin
          total_s = '0;
          state_s = ST_IDLE;
        end
      end
      default: begin
        total_s = '0;
        timer_s = '0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_DISPENSE) || (state_s == ST_RETURN);
  end

  // State, total, timer and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      total_r  <= '0;
      timer_r  <= '0;
      item_r   <= '0;
      ret_r    <= '0;
      reject_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      total_r  <= total_s;
      timer_r  <= timer_s;
      item_r   <= item_s;
      ret_r    <= ret_s;
      reject_r <= reject_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.o_available_item = avail_s;
  assign bus.o_output_item    = item_r;
  assign bus.o_return_coin    = ret_r;
  assign bus.o_coin_reject    = reject_r;
  assign bus.o_current_total  = total_r;
  assign bus.o_busy           = busy_r;
endmodule

// File: tb/tb_vending_machine_core.sv
// Directed test-plan scenarios plus randomized traffic, every cycle compared
// against a transaction-level model of the vending rules.
module tb_vending_machine_core;
  localparam int NI    = 4;
  localparam int NC    = 3;
  localparam int TBITS = 11;
  localparam int WC    = 10;
  localparam int MAXT  = (1 << TBITS) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_bad = 0;

  int pr[NI] = '{400, 500, 1000, 2000};
  int cv[NC] = '{100, 500, 1000};

  // Reference model: customer phase flags, credit, quiet-edge count, expected pulses.
  bit         m_wait, m_disp, m_ret;
  int         m_total, m_quiet;
  logic [3:0] e_item;
  logic [2:0] e_ret;
  logic       e_rej;

  vending_machine_core_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TBITS)) bus ();

  vending_machine_core #(
    .NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TBITS), .WAIT_CYCLES(WC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_avail();
    logic [3:0] a;
    a = 4'b0000;
    for (int i = 0; i < NI; i++) a[i] = m_wait && (m_total >= pr[i]);
    return a;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_disp = 1'b0; m_ret = 1'b0;
    m_total = 0; m_quiet = 0;
    e_item = 4'b0000; e_ret = 3'b000; e_rej = 1'b0;
  endtask

  task automatic model_step(input int cidx, input logic [3:0] sel, input logic rt);
    int v, pick, give;
    bit acc;
    logic [3:0] av;
    av  = model_avail();
    v   = (cidx >= 0) ? cv[cidx] : 0;
    acc = (cidx >= 0) && (m_total + v <= MAXT);
    e_item = 4'b0000; e_ret = 3'b000; e_rej = 1'b0;
    if (m_disp) begin
      e_rej  = (cidx >= 0);
      m_disp = 1'b0;
      if (m_total > 0) begin m_wait = 1'b1; m_quiet = 0; end
    end else if (m_ret) begin
      e_rej = (cidx >= 0);
      give  = -1;
      for (int j = 0; j < NC; j++) if (cv[j] <= m_total) give = j;
      if (give < 0) begin
        m_total = 0; m_ret = 1'b0;
      end else begin
        e_ret[give] = 1'b1; m_total -= cv[give];
      end
    end else if (m_wait) begin
      e_rej = (cidx >= 0) && !acc;
      if (acc) m_total += v;
      pick = -1;
      for (int i = NI - 1; i >= 0; i--) if (sel[i] && av[i]) pick = i;
      if (rt) begin
        m_wait = 1'b0; m_ret = 1'b1;
      end else if (pick >= 0) begin
        m_total -= pr[pick]; e_item[pick] = 1'b1;
        m_wait = 1'b0; m_disp = 1'b1;
      end else if (acc) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == WC + 1) begin m_wait = 1'b0; m_ret = 1'b1; end
      end
    end else begin
      if (acc) begin m_total += v; m_wait = 1'b1; m_quiet = 0; end
      else e_rej = (cidx >= 0);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_item"},  bus.o_output_item,   e_item);
    chk({pfx, "_ret"},   bus.o_return_coin,   e_ret);
    chk({pfx, "_rej"},   bus.o_coin_reject,   e_rej);
    chk({pfx, "_total"}, bus.o_current_total, m_total);
    chk({pfx, "_busy"},  bus.o_busy,          m_disp || m_ret);
  endtask

  task automatic cycle(input int cidx, input logic [3:0] sel, input logic rt);
    @(negedge clk);
    bus.i_input_coin     = (cidx >= 0) ? (3'b001 << cidx) : 3'b000;
    bus.i_select_item    = sel;
    bus.i_trigger_return = rt;
    chk("avail", bus.o_available_item, model_avail());
    model_step(cidx, sel, rt);
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic async_reset();
    #2;
    bus.i_input_coin = 3'b000; bus.i_select_item = 4'b0000; bus.i_trigger_return = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    chk("rst_avail", bus.o_available_item, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    logic [3:0] s;
    logic [2:0] seq[4];
    bus.i_input_coin = 3'b000; bus.i_select_item = 4'b0000; bus.i_trigger_return = 1'b0;
    for (int i = 0; i < NI; i++) bus.i_item_price[i*TBITS +: TBITS] = TBITS'(pr[i]);
    for (int j = 0; j < NC; j++) bus.i_coin_value[j*TBITS +: TBITS] = TBITS'(cv[j]);
    model_reset();
    async_reset();

    // Purchase: 1000 + 500, buy item1.
    cycle(2, 4'b0000, 1'b0); cycle(1, 4'b0000, 1'b0);
    chk("tp1_avail", bus.o_available_item, 4'b0111);
    cycle(-1, 4'b0010, 1'b0);
    chk("tp1_item", bus.o_output_item, 4'b0010);
    chk("tp1_busy", bus.o_busy, 1'b1);
    chk("tp1_total", bus.o_current_total, 1000);
    cycle(-1, 4'b0000, 1'b0);
    chk("tp1_wait_busy", bus.o_busy, 1'b0);
    async_reset();

    // Timeout: RETURN on the 11th idle edge after the insert.
    cycle(1, 4'b0000, 1'b0);
    for (int k = 0; k < WC; k++) begin
      cycle(-1, 4'b0000, 1'b0);
      chk("tp2_not_yet", bus.o_busy, 1'b0);
    end
    cycle(-1, 4'b0000, 1'b0);
    chk("tp2_timeout", bus.o_busy, 1'b1);
    cycle(-1, 4'b0000, 1'b0);
    chk("tp2_coin", bus.o_return_coin, 3'b010);
    cycle(-1, 4'b0000, 1'b0);
    chk("tp2_idle_total", bus.o_current_total, 0);
    chk("tp2_idle_busy", bus.o_busy, 1'b0);

    // Explicit return of 1700: greedy 1000,500,100,100.
    cycle(2, 4'b0000, 1'b0); cycle(1, 4'b0000, 1'b0);
    cycle(0, 4'b0000, 1'b0); cycle(0, 4'b0000, 1'b0);
    cycle(-1, 4'b0000, 1'b1);
    seq = '{3'b100, 3'b010, 3'b001, 3'b001};
    for (int k = 0; k < 4; k++) begin
      cycle(-1, 4'b0000, 1'b0);
      chk("tp3_pulse", bus.o_return_coin, seq[k]);
    end
    cycle(-1, 4'b0000, 1'b0);
    chk("tp3_done", bus.o_busy, 1'b0);

    // Overflow reject at 11 bits, then lowest selected item.
    cycle(2, 4'b0000, 1'b0); cycle(2, 4'b0000, 1'b0); cycle(0, 4'b0000, 1'b0);
    chk("tp4_rej", bus.o_coin_reject, 1'b1);
    chk("tp4_total", bus.o_current_total, 2000);
    cycle(-1, 4'b0101, 1'b0);
    chk("tp4_item", bus.o_output_item, 4'b0001);
    chk("tp4_total2", bus.o_current_total, 1600);
    async_reset();

    // Same-cycle coin+select uses pre-coin credit; coin during DISPENSE refused.
    for (int k = 0; k < 4; k++) cycle(0, 4'b0000, 1'b0);
    cycle(1, 4'b0010, 1'b0);
    chk("tp5_noitem", bus.o_output_item, 4'b0000);
    chk("tp5_total", bus.o_current_total, 900);
    cycle(-1, 4'b0001, 1'b0);
    cycle(0, 4'b0000, 1'b0);
    chk("tp5_disp_rej", bus.o_coin_reject, 1'b1);
    chk("tp5_total2", bus.o_current_total, 500);
    async_reset();

    // Asynchronous reset after the first change pulse.
    cycle(2, 4'b0000, 1'b0); cycle(1, 4'b0000, 1'b0); cycle(-1, 4'b0000, 1'b1);
    cycle(-1, 4'b0000, 1'b0);
    chk("tp6_first", bus.o_return_coin, 3'b100);
    async_reset();
    cycle(-1, 4'b0000, 1'b0);
    chk("tp6_idle", bus.o_busy, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      c  = ($urandom_range(9, 0) < 3) ? int'($urandom_range(NC - 1, 0)) : -1;
      s  = ($urandom_range(9, 0) < 3) ? 4'($urandom_range(15, 0)) : 4'b0000;
      cycle(c, s, $urandom_range(39, 0) == 0);
      if ($urandom_range(499, 0) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
